// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl
//   Miss-handling controller shared by the instruction and data caches. One
//   line miss is serviced at a time over a word-serial memory port: a dirty
//   d-side victim line is written back first, then the missing line is read
//   and streamed into the owning cache, and a one-cycle done pulse closes
//   the transaction.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   i_miss_req / i_miss_addr      i-cache miss request and byte address
//   d_miss_req / d_miss_addr      d-cache miss request and byte address
//   d_dirty / d_victim_addr       victim state, sampled when the d side is granted
//   d_victim_idx / d_victim_data  combinational victim-word read port
//   fill_idx / fill_data          fill word index and data
//   i_fill_we / d_fill_we         fill write strobes, one per cache
//   i_fill_done / d_fill_done     one-cycle line-complete pulses
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata  memory word port
//
// Memory handshake: mem_req and mem_addr/mem_we/mem_wdata stay stable until a
// cycle with mem_ack high; that cycle transfers the word (mem_rdata is valid
// then for reads) and the next word, if any, is presented on the following
// cycle with mem_req still high. mem_ack is ignored while mem_req is low.
module cache_miss_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 16,
    parameter int ARB_MODE   = 0,
    localparam int IDX_W     = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_miss_req,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss_req,
    input  logic [ADDR_W-1:0] d_miss_addr,
    input  logic              d_dirty,
    input  logic [ADDR_W-1:0] d_victim_addr,
    output logic [IDX_W-1:0]  d_victim_idx,
    input  logic [DATA_W-1:0] d_victim_data,
    output logic [IDX_W-1:0]  fill_idx,
    output logic [DATA_W-1:0] fill_data,
    output logic              i_fill_we,
    output logic              d_fill_we,
    output logic              i_fill_done,
    output logic              d_fill_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WORD_BYTES = DATA_W / 8;
    localparam int STEP_SH    = $clog2(WORD_BYTES);
    localparam int OFF_W      = $clog2(LINE_WORDS * WORD_BYTES);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOC, DONE} state_t;

    state_t            state;
    logic [IDX_W-1:0]  cnt;
    logic              owner_d;       // 1: current line belongs to the d-cache
    logic              last_grant_d;  // side granted most recently
    logic [ADDR_W-1:0] victim_base;
    logic [ADDR_W-1:0] miss_base;
    logic              grant_d;
    logic [ADDR_W-1:0] word_off;

    // D wins when alone, always under fixed priority, and under round-robin
    // only when the previous grant went to I.
    assign grant_d  = d_miss_req && (!i_miss_req || (ARB_MODE == 0) || !last_grant_d);
    assign word_off = ADDR_W'(cnt) << STEP_SH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            owner_d      <= 1'b0;
            last_grant_d <= 1'b0;
            victim_base  <= '0;
            miss_base    <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            i_fill_done  <= 1'b0;
            d_fill_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_miss_req || d_miss_req) begin
                        owner_d      <= grant_d;
                        last_grant_d <= grant_d;
                        cnt          <= '0;
                        victim_base  <= d_victim_addr & LINE_MASK;
                        miss_base    <= (grant_d ? d_miss_addr : i_miss_addr) & LINE_MASK;
                        mem_req      <= 1'b1;
                        mem_we       <= grant_d && d_dirty;
                        state        <= (grant_d && d_dirty) ? WRITEBACK : ALLOC;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        // cnt wraps to 0 on the last word since LINE_WORDS is a power of 2
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_IDX) begin
                            mem_we <= 1'b0;
                            state  <= ALLOC;
                        end
                    end
                end
                ALLOC: begin
                    if (mem_ack) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_IDX) begin
                            mem_req     <= 1'b0;
                            i_fill_done <= !owner_d;
                            d_fill_done <= owner_d;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    i_fill_done <= 1'b0;
                    d_fill_done <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath decode from the registered state; fill strobes follow mem_ack
    // within the same cycle so the cache captures mem_rdata as it arrives.
    always_comb begin
        mem_addr     = '0;
        mem_wdata    = '0;
        d_victim_idx = '0;
        fill_idx     = '0;
        fill_data    = '0;
        i_fill_we    = 1'b0;
        d_fill_we    = 1'b0;
        case (state)
            WRITEBACK: begin
                mem_addr     = victim_base + word_off;
                d_victim_idx = cnt;
                mem_wdata    = d_victim_data;
            end
            ALLOC: begin
                mem_addr  = miss_base + word_off;
                fill_idx  = cnt;
                fill_data = mem_rdata;
                i_fill_we = mem_ack && !owner_d;
                d_fill_we = mem_ack && owner_d;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl. Three instances run side by side:
//   u0: 16 x 32-bit lines, fixed d-side priority
//   u1: 16 x 32-bit lines, round-robin arbitration
//   u2: 4 x 64-bit lines, fixed d-side priority
// The reference model views a transaction as a flat list of memory words
// (optional writeback words, then fill words) followed by one done cycle.
module tb_cache_miss_ctrl;

    logic clk;
    logic rst_n;

    logic [2:0]       i_req, d_req, dirty, ack;
    logic [2:0][31:0] i_addr, d_addr, vaddr, vseed;
    logic [2:0][63:0] rdata, vdata;

    logic [2:0]       o_req, o_we, o_ifwe, o_dfwe, o_idone, o_ddone;
    logic [2:0][31:0] o_addr;
    logic [2:0][63:0] o_wdata, o_fdata;
    logic [2:0][3:0]  o_vidx, o_fidx;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rand_done = 0;

    // model state per instance
    bit          m_busy[3];
    bit          m_own_d[3];
    bit          m_last_d[3];
    int          m_k[3], m_wb[3], m_total[3];
    logic [31:0] m_vbase[3], m_mbase[3];

    // requester / environment state
    bit seen_idone[3], seen_ddone[3];
    bit pend_i[3], pend_d[3];
    int stall[3];
    bit rand_on = 0;
    bit raise_on = 0;

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    cache_miss_ctrl #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(16), .ARB_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .i_miss_req(i_req[0]), .i_miss_addr(i_addr[0]),
        .d_miss_req(d_req[0]), .d_miss_addr(d_addr[0]),
        .d_dirty(dirty[0]), .d_victim_addr(vaddr[0]),
        .d_victim_idx(o_vidx[0]), .d_victim_data(vdata[0][31:0]),
        .fill_idx(o_fidx[0]), .fill_data(o_fdata[0][31:0]),
        .i_fill_we(o_ifwe[0]), .d_fill_we(o_dfwe[0]),
        .i_fill_done(o_idone[0]), .d_fill_done(o_ddone[0]),
        .mem_req(o_req[0]), .mem_we(o_we[0]), .mem_addr(o_addr[0]),
        .mem_wdata(o_wdata[0][31:0]), .mem_ack(ack[0]), .mem_rdata(rdata[0][31:0])
    );

    cache_miss_ctrl #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(16), .ARB_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .i_miss_req(i_req[1]), .i_miss_addr(i_addr[1]),
        .d_miss_req(d_req[1]), .d_miss_addr(d_addr[1]),
        .d_dirty(dirty[1]), .d_victim_addr(vaddr[1]),
        .d_victim_idx(o_vidx[1]), .d_victim_data(vdata[1][31:0]),
        .fill_idx(o_fidx[1]), .fill_data(o_fdata[1][31:0]),
        .i_fill_we(o_ifwe[1]), .d_fill_we(o_dfwe[1]),
        .i_fill_done(o_idone[1]), .d_fill_done(o_ddone[1]),
        .mem_req(o_req[1]), .mem_we(o_we[1]), .mem_addr(o_addr[1]),
        .mem_wdata(o_wdata[1][31:0]), .mem_ack(ack[1]), .mem_rdata(rdata[1][31:0])
    );

    cache_miss_ctrl #(.ADDR_W(32), .DATA_W(64), .LINE_WORDS(4), .ARB_MODE(0)) u2 (
        .clk(clk), .rst_n(rst_n),
        .i_miss_req(i_req[2]), .i_miss_addr(i_addr[2]),
        .d_miss_req(d_req[2]), .d_miss_addr(d_addr[2]),
        .d_dirty(dirty[2]), .d_victim_addr(vaddr[2]),
        .d_victim_idx(o_vidx[2][1:0]), .d_victim_data(vdata[2]),
        .fill_idx(o_fidx[2][1:0]), .fill_data(o_fdata[2]),
        .i_fill_we(o_ifwe[2]), .d_fill_we(o_dfwe[2]),
        .i_fill_done(o_idone[2]), .d_fill_done(o_ddone[2]),
        .mem_req(o_req[2]), .mem_we(o_we[2]), .mem_addr(o_addr[2]),
        .mem_wdata(o_wdata[2]), .mem_ack(ack[2]), .mem_rdata(rdata[2])
    );

    assign o_wdata[0][63:32] = '0;
    assign o_wdata[1][63:32] = '0;
    assign o_fdata[0][63:32] = '0;
    assign o_fdata[1][63:32] = '0;
    assign o_vidx[2][3:2]    = '0;
    assign o_fidx[2][3:2]    = '0;

    function automatic int lw(input int n);
        return (n == 2) ? 4 : 16;
    endfunction

    function automatic int bpw(input int n);
        return (n == 2) ? 8 : 4;
    endfunction

    function automatic logic [63:0] dmask(input int n);
        return (n == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    // victim cache contents: a pure function of the per-line seed and word index
    function automatic logic [63:0] vword(input logic [31:0] s, input int idx);
        return {s ^ 32'hFFFF_0000, s ^ (32'(idx) * 32'h9E37_79B9)};
    endfunction

    always_comb begin
        for (int n = 0; n < 3; n++) vdata[n] = vword(vseed[n], int'(o_vidx[n]));
    end

    function automatic string nm(input int n, input string s);
        return $sformatf("u%0d_%s", n, s);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual 0x%0h required 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t: actual timeout required completion", name, $time);
    endtask

    // scoreboard: compare every output every cycle, then advance the model
    always @(negedge clk) begin
        int k, wb, tot, b;
        logic e_req, e_we, e_fill, e_done, gd;
        logic [31:0] e_addr, lmask;
        for (int n = 0; n < 3; n++) begin
            seen_idone[n] = o_idone[n];
            seen_ddone[n] = o_ddone[n];
            if (!rst_n) begin
                check(nm(n, "rst_req"),   o_req[n],   0);
                check(nm(n, "rst_fwe"),   {o_ifwe[n], o_dfwe[n]}, 0);
                check(nm(n, "rst_done"),  {o_idone[n], o_ddone[n]}, 0);
                check(nm(n, "rst_addr"),  o_addr[n],  0);
                m_busy[n]   = 0;
                m_own_d[n]  = 0;
                m_last_d[n] = 0;
                m_k[n]      = 0;
            end else begin
                k = m_k[n]; wb = m_wb[n]; tot = m_total[n]; b = bpw(n);
                e_req  = m_busy[n] && (k < tot);
                e_we   = e_req && (k < wb);
                e_fill = e_req && !e_we && ack[n];
                e_done = m_busy[n] && (k == tot);
                e_addr = (k < wb) ? m_vbase[n] + 32'(k * b) : m_mbase[n] + 32'((k - wb) * b);
                check(nm(n, "mem_req"), o_req[n], e_req);
                check(nm(n, "i_fill_we"), o_ifwe[n], e_fill && !m_own_d[n]);
                check(nm(n, "d_fill_we"), o_dfwe[n], e_fill && m_own_d[n]);
                check(nm(n, "i_fill_done"), o_idone[n], e_done && !m_own_d[n]);
                check(nm(n, "d_fill_done"), o_ddone[n], e_done && m_own_d[n]);
                if (e_req) begin
                    check(nm(n, "mem_we"), o_we[n], e_we);
                    check(nm(n, "mem_addr"), o_addr[n], e_addr);
                end
                if (e_we) begin
                    check(nm(n, "victim_idx"), o_vidx[n], k);
                    check(nm(n, "mem_wdata"), o_wdata[n], vword(vseed[n], k) & dmask(n));
                end
                if (e_fill) begin
                    check(nm(n, "fill_idx"), o_fidx[n], k - wb);
                    check(nm(n, "fill_data"), o_fdata[n], rdata[n] & dmask(n));
                end
                if (rand_on && e_done) n_rand_done++;
                // advance
                if (!m_busy[n]) begin
                    if (i_req[n] || d_req[n]) begin
                        gd = d_req[n] && (!i_req[n] || (n != 1) || !m_last_d[n]);
                        lmask = ~(32'(lw(n) * b) - 32'd1);
                        m_own_d[n]  = gd;
                        m_last_d[n] = gd;
                        m_vbase[n]  = vaddr[n] & lmask;
                        m_mbase[n]  = (gd ? d_addr[n] : i_addr[n]) & lmask;
                        m_wb[n]     = (gd && dirty[n]) ? lw(n) : 0;
                        m_total[n]  = m_wb[n] + lw(n);
                        m_k[n]      = 0;
                        m_busy[n]   = 1;
                    end
                end else if (k < tot) begin
                    if (ack[n]) m_k[n] = k + 1;
                end else begin
                    m_busy[n] = 0;
                end
            end
        end
    end

    // requesters and memory: drop req at the edge ending the done cycle,
    // random traffic with 0-5 cycle ack stalls when enabled
    always @(posedge clk) begin
        #1;
        for (int n = 0; n < 3; n++) begin
            rdata[n] = {$urandom, $urandom};
            if (seen_idone[n]) begin i_req[n] = 1'b0; pend_i[n] = 0; end
            if (seen_ddone[n]) begin d_req[n] = 1'b0; pend_d[n] = 0; end
            if (rand_on) begin
                if (stall[n] == 0) begin
                    ack[n] = 1'b1;
                    stall[n] = $urandom_range(0, 5);
                end else begin
                    ack[n] = 1'b0;
                    stall[n]--;
                end
                // post-grant changes must not disturb the line in service
                if (m_busy[n] && !m_own_d[n] && pend_i[n]) begin
                    i_addr[n] = $urandom;
                    if ($urandom_range(0, 15) == 0) i_req[n] = 1'b0;
                end
                if (m_busy[n] && m_own_d[n] && pend_d[n]) begin
                    d_addr[n] = $urandom;
                    vaddr[n]  = $urandom;
                    dirty[n]  = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 15) == 0) d_req[n] = 1'b0;
                end
                if (raise_on && !pend_i[n] && $urandom_range(0, 4) == 0) begin
                    i_req[n] = 1'b1; i_addr[n] = $urandom; pend_i[n] = 1;
                end
                if (raise_on && !pend_d[n] && $urandom_range(0, 4) == 0) begin
                    d_req[n] = 1'b1; d_addr[n] = $urandom; vaddr[n] = $urandom;
                    dirty[n] = 1'($urandom_range(0, 1)); vseed[n] = $urandom; pend_d[n] = 1;
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic measure(input int n, input bit side_d, output int cyc, output int nfill,
                           output int nwr, output logic [31:0] first_rd, output logic [31:0] last_rd,
                           output logic [31:0] first_wr, output logic [63:0] first_wd);
        cyc = 0; nfill = 0; nwr = 0;
        first_rd = '0; last_rd = '0; first_wr = '0; first_wd = '0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (side_d ? o_dfwe[n] : o_ifwe[n]) begin
                if (nfill == 0) first_rd = o_addr[n];
                last_rd = o_addr[n];
                nfill++;
            end
            if (o_req[n] && o_we[n] && ack[n]) begin
                if (nwr == 0) begin first_wr = o_addr[n]; first_wd = o_wdata[n]; end
                nwr++;
            end
            if (side_d ? o_ddone[n] : o_idone[n]) break;
            if (cyc >= 400) begin timeout_fail(nm(n, "measure")); break; end
        end
    endtask

    task automatic wait_any_done(input int n, output bit was_d);
        int c;
        c = 0;
        was_d = 0;
        while (1) begin
            @(negedge clk);
            c++;
            if (o_idone[n] || o_ddone[n]) begin was_d = o_ddone[n]; break; end
            if (c >= 400) begin timeout_fail(nm(n, "wait_done")); break; end
        end
    endtask

    initial begin
        int cyc, nfill, nwr, c;
        logic [31:0] frd, lrd, fwr;
        logic [63:0] fwd;
        bit was_d, idle_all;
        logic [3:0] seq;

        rst_n = 1'b0;
        i_req = '0; d_req = '0; dirty = '0; ack = '0;
        i_addr = '0; d_addr = '0; vaddr = '0; vseed = '0;
        for (int n = 0; n < 3; n++) begin stall[n] = 0; pend_i[n] = 0; pend_d[n] = 0; end
        repeat (3) @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();

        // clean i miss, ack every cycle
        ack[0] = 1'b1; i_addr[0] = 32'h0000_1234; i_req[0] = 1'b1;
        measure(0, 0, cyc, nfill, nwr, frd, lrd, fwr, fwd);
        check("t1_first_addr", frd, 32'h0000_1200);
        check("t1_last_addr", lrd, 32'h0000_123C);
        check("t1_fill_count", nfill, 16);
        check("t1_done_cycle", cyc, 18);
        tick(); tick();

        // dirty d miss: writeback then fill
        d_addr[0] = 32'h0000_4010; vaddr[0] = 32'h0000_8000; dirty[0] = 1'b1;
        vseed[0] = 32'h1111_0000; d_req[0] = 1'b1;
        measure(0, 1, cyc, nfill, nwr, frd, lrd, fwr, fwd);
        check("t2_first_wr_addr", fwr, 32'h0000_8000);
        check("t2_wr_count", nwr, 16);
        check("t2_first_wdata", fwd, 64'h0000_0000_1111_0000);
        check("t2_first_rd_addr", frd, 32'h0000_4000);
        check("t2_last_rd_addr", lrd, 32'h0000_403C);
        check("t2_fill_count", nfill, 16);
        check("t2_done_cycle", cyc, 34);
        tick(); tick();
        dirty[0] = 1'b0;

        // simultaneous requests, fixed priority
        i_addr[0] = 32'h0000_2000; d_addr[0] = 32'h0000_3000; i_req[0] = 1'b1; d_req[0] = 1'b1;
        wait_any_done(0, was_d);
        check("t3_fixed_first_is_d", was_d, 1);
        wait_any_done(0, was_d);
        check("t3_fixed_second_is_i", was_d, 0);
        tick(); tick();
        ack[0] = 1'b0;

        // simultaneous requests, round-robin, two rounds
        ack[1] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            i_addr[1] = 32'h0000_6000 + 32'(r * 64); d_addr[1] = 32'h0000_7000 + 32'(r * 64);
            i_req[1] = 1'b1; d_req[1] = 1'b1;
            wait_any_done(1, was_d);
            seq[3 - 2 * r] = was_d;
            wait_any_done(1, was_d);
            seq[2 - 2 * r] = was_d;
            tick(); tick();
        end
        check("t3_rr_grant_order", seq, 4'b1010);
        ack[1] = 1'b0;

        // short wide lines; spurious acks while idle
        ack[2] = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("t6_idle_req", o_req[2], 0);
        tick();
        d_addr[2] = 32'h0000_1238; dirty[2] = 1'b0; d_req[2] = 1'b1;
        measure(2, 1, cyc, nfill, nwr, frd, lrd, fwr, fwd);
        check("t6_first_addr", frd, 32'h0000_1220);
        check("t6_last_addr", lrd, 32'h0000_1238);
        check("t6_fill_count", nfill, 4);
        check("t6_done_cycle", cyc, 6);
        tick(); tick();
        ack[2] = 1'b0;

        // reset in the middle of a fill
        ack[0] = 1'b1; i_addr[0] = 32'h0000_5678; i_req[0] = 1'b1;
        c = 0;
        while (1) begin
            @(negedge clk);
            c++;
            if (o_ifwe[0] && o_fidx[0] == 4'd7) break;
            if (c >= 100) begin timeout_fail("t5_reach_word7"); break; end
        end
        #2;
        rst_n = 1'b0;
        i_req[0] = 1'b0;
        #1;
        check("t5_req_drop", o_req[0], 0);
        check("t5_fwe_drop", o_ifwe[0], 0);
        repeat (2) @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();
        i_req[0] = 1'b1;
        measure(0, 0, cyc, nfill, nwr, frd, lrd, fwr, fwd);
        check("t5_retry_first_addr", frd, 32'h0000_5640);
        check("t5_retry_fill_count", nfill, 16);
        check("t5_retry_done_cycle", cyc, 18);
        tick(); tick();
        ack[0] = 1'b0;

        // randomized traffic with stalls on all three instances
        rand_on = 1; raise_on = 1;
        repeat (4000) @(posedge clk);
        raise_on = 0;
        idle_all = 0;
        for (int w = 0; w < 4000; w++) begin
            @(negedge clk);
            idle_all = 1;
            for (int n = 0; n < 3; n++)
                if (pend_i[n] || pend_d[n] || m_busy[n]) idle_all = 0;
            if (idle_all) break;
        end
        if (!idle_all) timeout_fail("drain");
        rand_on = 0;
        check("rand_activity", n_rand_done >= 30, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        timeout_fail("watchdog");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
